stream_fifo_vr: RTL and testbench
=================================

Name: stream_fifo_vr

Overview:
Parametrised single-clock FIFO with valid/ready handshakes on both sides, first-word-fall-through output, occupancy count, programmable almost-full/almost-empty flags and synchronous flush. It generalises the team's fixed-width buffering into one reusable block placed between any producer/consumer pair in the datapath. Storage is a register array; no vendor RAM macros.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 16, entries; power of two, >=2
AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear; discards all stored entries
s_valid  in  1  producer has data
s_ready  out  1  FIFO can accept; equals !full
s_data  in  DATA_W  write data
m_valid  out  1  head entry valid; equals !empty
m_ready  in  1  consumer accepts head
m_data  out  DATA_W  head entry (FWFT)
count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
overflow_err  out  1  sticky; set on s_valid while full (attempted write dropped)

Behaviour:
- Reset (rst_n low, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, s_ready=1, m_valid=0, almost_empty=1, almost_full=0 (AF_LEVEL>0), overflow_err=0, m_data=0. Storage contents are not reset.
- Push = s_valid & s_ready; pop = m_valid & m_ready. Both evaluated at the same rising edge.
- Push: mem[wr_ptr]<=s_data, wr_ptr wraps modulo DEPTH. Pop: rd_ptr wraps modulo DEPTH.
- count: +1 push only, -1 pop only, unchanged on both or neither. Flags derive from count registered in the same edge (no extra cycle).
- Latency: word pushed at edge N into an empty FIFO gives m_valid=1 and m_data=word after edge N (visible in cycle N+1). No combinational s->m path.
- m_data = mem[rd_ptr]; it must remain stable while m_valid=1 and m_ready=0.
- Full: s_ready=0; no pass-through even if m_ready=1 in that cycle. s_ready rises the cycle after a pop.
- Empty: m_valid=0; m_ready is ignored; a pop never underflows pointers or count.
- Simultaneous push+pop at count=1: the head is replaced by the new word next cycle; count stays 1.
- flush=1 at edge: pointers and count go to 0 and flags go to their reset values; any push/pop in that cycle is discarded. overflow_err is cleared only by reset or flush.
- overflow_err sets at the edge where s_valid=1 and full=1 and flush=0.
- Reset asserted mid-transfer: immediate return to reset state; a partially accepted beat does not exist (single-cycle transfers).

Test Plan:
- Reset, push 0x01..0x10 with m_ready=0 -> count=16, full=1, s_ready=0, almost_full from count 14; then pop all -> m_data 0x01..0x10 in order, empty=1 after the 16th pop.
- Single push of 0xA5 into empty FIFO at edge N -> m_valid=1 and m_data=0xA5 in cycle N+1, count=1, almost_empty=1.
- Continuous s_valid=m_valid=1 streaming 64 words with count held at 3 -> count constant 3, output sequence matches input, pointer wrap crossed 4 times with no loss.
- Fill to 16, hold s_valid=1 for 2 cycles -> overflow_err=1 sticky, no entry overwritten; pop one -> s_ready=1 next cycle, next push accepted.
- Count=9, assert flush together with push+pop -> count=0, empty=1, overflow_err=0; next push of 0x3C appears as m_data.
- Drop rst_n asynchronously mid-stream at count=7 -> outputs take reset values before the next clock edge; after release the FIFO behaves as empty.

Source files
------------

// File: rtl/stream_fifo_vr.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on both
// sides, occupancy count, almost-full/almost-empty flags and a sticky overflow flag.
module stream_fifo_vr #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign s_ready      = !full;
    assign m_valid      = !empty;
    assign count        = count_q;
    assign overflow_err = overflow_q;

    // The head is forced to zero while empty so the unreset storage never leaks out.
    assign m_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        push       = s_valid && !full;
        pop        = m_ready && !empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
            if (s_valid && full) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= s_data;
    end

endmodule

// File: tb/tb_stream_fifo_vr.sv
// Randomised testbench for stream_fifo_vr, checked against a queue-based
// model of FIFO occupancy, ordering and the sticky overflow flag.
module tb_stream_fifo_vr;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow_err;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] mq[$];
    logic       mOvf = 1'b0;

    stream_fifo_vr #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic sv, input logic mr, input logic fl, input logic [7:0] d);
        bit doPush, doPop;
        if (fl) begin
            mq.delete();
            mOvf = 1'b0;
        end else begin
            doPush = sv && (mq.size() < DEPTH);
            doPop  = mr && (mq.size() > 0);
            if (sv && mq.size() == DEPTH) mOvf = 1'b1;
            if (doPop) void'(mq.pop_front());
            if (doPush) mq.push_back(d);
        end
    endtask

    // Drive one clock cycle of inputs; returns 1 time unit after the rising edge.
    task automatic cycle(input logic sv, input logic mr, input logic fl, input logic [7:0] d);
        s_valid = sv;
        m_ready = mr;
        flush   = fl;
        s_data  = d;
        @(posedge clk);
        model_edge(sv, mr, fl, d);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        #12;
        nChecks++; if (count !== 5'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        nChecks++; if (empty !== 1'b1 || full !== 1'b0) begin nFails++; $display("[TB] FAIL reset_empty_full: got %b%b expected 10", empty, full); end
        nChecks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_handshake: got s_ready=%b m_valid=%b expected 1/0", s_ready, m_valid); end
        nChecks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin nFails++; $display("[TB] FAIL reset_almost: got ae=%b af=%b expected 1/0", almost_empty, almost_full); end
        nChecks++; if (overflow_err !== 1'b0 || m_data !== 8'h00) begin nFails++; $display("[TB] FAIL reset_ovf_data: got ovf=%b data=%0h expected 0/00", overflow_err, m_data); end
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'(i));
            nChecks++; if (count !== 5'(i)) begin nFails++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, i); end
            nChecks++; if (almost_full !== (i >= 14) || full !== (i == 16)) begin nFails++; $display("[TB] FAIL fill_flags at %0d: got af=%b full=%b", i, almost_full, full); end
        end
        nChecks++; if (s_ready !== 1'b0) begin nFails++; $display("[TB] FAIL fill_s_ready: got %b expected 0", s_ready); end
        for (int i = 1; i <= 16; i++) begin
            nChecks++; if (m_data !== 8'(i) || m_valid !== 1'b1) begin nFails++; $display("[TB] FAIL drain_data: got %0h valid=%b expected %0h", m_data, m_valid, i); end
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
        end
        nChecks++; if (empty !== 1'b1 || count !== 5'd0) begin nFails++; $display("[TB] FAIL drain_empty: got empty=%b count=%0d expected 1/0", empty, count); end
    endtask

    task automatic test_single();
        cycle(1'b1, 1'b0, 1'b0, 8'hA5);
        s_valid = 1'b0;
        nChecks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin nFails++; $display("[TB] FAIL single_head: got valid=%b data=%0h expected 1/a5", m_valid, m_data); end
        nChecks++; if (count !== 5'd1 || almost_empty !== 1'b1) begin nFails++; $display("[TB] FAIL single_count: got count=%0d ae=%b expected 1/1", count, almost_empty); end
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        nChecks++; if (empty !== 1'b1) begin nFails++; $display("[TB] FAIL single_pop: got empty=%b expected 1", empty); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
            nChecks++; if (count !== 5'd3) begin nFails++; $display("[TB] FAIL stream_count: got %0d expected 3", count); end
            nChecks++; if (m_data !== mq[0] || m_valid !== 1'b1 || s_ready !== 1'b1) begin nFails++; $display("[TB] FAIL stream_data: got %0h expected %0h", m_data, mq[0]); end
        end
        while (mq.size() > 0) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_overflow();
        while (mq.size() < DEPTH) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b0, 1'b0, 8'hEE);
        cycle(1'b1, 1'b0, 1'b0, 8'hEF);
        nChecks++; if (overflow_err !== mOvf || count !== 5'd16 || s_ready !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_set: got ovf=%b count=%0d s_ready=%b expected 1/16/0", overflow_err, count, s_ready); end
        nChecks++; if (m_data !== mq[0]) begin nFails++; $display("[TB] FAIL ovf_head: got %0h expected %0h", m_data, mq[0]); end
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        nChecks++; if (s_ready !== 1'b1 || count !== 5'd15 || overflow_err !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_pop: got s_ready=%b count=%0d ovf=%b expected 1/15/1", s_ready, count, overflow_err); end
        cycle(1'b1, 1'b0, 1'b0, 8'h77);
        nChecks++; if (count !== 5'd16 || full !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_repush: got count=%0d full=%b expected 16/1", count, full); end
        while (mq.size() > 0) begin
            nChecks++; if (m_data !== mq[0]) begin nFails++; $display("[TB] FAIL ovf_order: got %0h expected %0h", m_data, mq[0]); end
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
        end
        nChecks++; if (overflow_err !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_err); end
    endtask

    task automatic test_flush();
        while (mq.size() < 9) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 1'b1, 8'h55);
        nChecks++; if (count !== 5'd0 || empty !== 1'b1 || m_valid !== 1'b0) begin nFails++; $display("[TB] FAIL flush_count: got count=%0d empty=%b m_valid=%b expected 0/1/0", count, empty, m_valid); end
        nChecks++; if (overflow_err !== 1'b0 || s_ready !== 1'b1 || almost_empty !== 1'b1) begin nFails++; $display("[TB] FAIL flush_flags: got ovf=%b s_ready=%b ae=%b expected 0/1/1", overflow_err, s_ready, almost_empty); end
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        nChecks++; if (m_data !== 8'h3C || count !== 5'd1) begin nFails++; $display("[TB] FAIL flush_repush: got data=%0h count=%0d expected 3c/1", m_data, count); end
    endtask

    task automatic test_async_reset();
        while (mq.size() < 7) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        s_valid = 1'b1; m_ready = 1'b1; s_data = 8'h99;
        #2 rst_n = 1'b0;
        #1;
        mq.delete(); mOvf = 1'b0;
        nChecks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin nFails++; $display("[TB] FAIL arst_count: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); end
        nChecks++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h00) begin nFails++; $display("[TB] FAIL arst_outputs: got m_valid=%b s_ready=%b data=%0h expected 0/1/00", m_valid, s_ready, m_data); end
        s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 8'h42);
        nChecks++; if (count !== 5'd1 || m_data !== 8'h42) begin nFails++; $display("[TB] FAIL arst_after: got count=%0d data=%0h expected 1/42", count, m_data); end
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic sv, mr, fl;
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                sv = ($urandom_range(0, 3) != 0);
                mr = ($urandom_range(0, 3) == 0);
            end else begin
                sv = ($urandom_range(0, 3) == 0);
                mr = ($urandom_range(0, 3) != 0);
            end
            fl = ($urandom_range(0, 59) == 0);
            cycle(sv, mr, fl, 8'($urandom));
            nChecks++; if (count !== 5'(mq.size())) begin nFails++; $display("[TB] FAIL rand_count: got %0d expected %0d", count, mq.size()); end
            nChecks++; if (full !== (mq.size() == DEPTH) || s_ready !== (mq.size() != DEPTH)) begin nFails++; $display("[TB] FAIL rand_full: got full=%b s_ready=%b size=%0d", full, s_ready, mq.size()); end
            nChecks++; if (empty !== (mq.size() == 0) || m_valid !== (mq.size() != 0)) begin nFails++; $display("[TB] FAIL rand_empty: got empty=%b m_valid=%b size=%0d", empty, m_valid, mq.size()); end
            nChecks++; if (almost_full !== (mq.size() >= 14) || almost_empty !== (mq.size() <= 2)) begin nFails++; $display("[TB] FAIL rand_almost: got af=%b ae=%b size=%0d", almost_full, almost_empty, mq.size()); end
            nChecks++; if (overflow_err !== mOvf) begin nFails++; $display("[TB] FAIL rand_ovf: got %b expected %b", overflow_err, mOvf); end
            if (mq.size() > 0) begin
                nChecks++; if (m_data !== mq[0]) begin nFails++; $display("[TB] FAIL rand_data: got %0h expected %0h", m_data, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_single();
        test_stream();
        test_overflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
